// File: rtl/key_schedule_sequencer.sv
// DES key schedule sequencer: rotates the post-PC-1 C||D register per round and presents
// PC-2 subkeys on a valid/ready handshake, K1..K16 for encrypt or K16..K1 for decrypt.
module key_schedule_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] cd_in,
  input  logic        abort,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // PC-2 selection, 1-based DES bit numbers over C||D (DES bit 1 = cd[55]).
  localparam logic [5:0] Pc2Tab [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  logic [1:0]  state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int i = 0; i < 48; i++) begin
      k[47-i] = cd[6'(56 - Pc2Tab[i])];
    end
    return k;
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right,
                                         input logic [1:0] amt);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 2; i++) begin
      if (int'(amt) > i) begin
        if (right) begin
          c = {c[0], c[27:1]};
          d = {d[0], d[27:1]};
        end else begin
          c = {c[26:0], c[27]};
          d = {d[26:0], d[27]};
        end
      end
    end
    return {c, d};
  endfunction

  // Shift applied when entering round r (1..16); decrypt is the encrypt schedule reversed.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [4:0] r);
    if (r == 5'd1) return dec ? 2'd0 : 2'd1;
    if (r == 5'd2 || r == 5'd9 || r == 5'd16) return 2'd1;
    return 2'd2;
  endfunction

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cd_d    = rot_cd(cd_in, decrypt, shift_amt(decrypt, 5'd1));
          dec_d   = decrypt;
          idx_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          idx_d   = 4'd0;
          state_d = StIdle;
        end else if (subkey_ready) begin
          if (idx_q == 4'd15) begin
            // Decrypt has rotated 27 so far; one more right step restores the loaded key.
            cd_d    = rot_cd(cd_q, dec_q, {1'b0, dec_q});
            state_d = StDone;
          end else begin
            cd_d  = rot_cd(cd_q, dec_q, shift_amt(dec_q, {1'b0, idx_q} + 5'd2));
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: begin
        idx_d   = 4'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cd_q    <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
    end
  end

  assign subkey       = pc2(cd_q);
  assign subkey_valid = (state_q == StRun);
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign round_idx    = idx_q;

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Bench for key_schedule_sequencer: a DES key-schedule model built from cumulative rotations
// is checked every cycle, plus directed scenarios with literal subkey expectations.
module tb_key_schedule_sequencer;

  localparam logic [55:0] Cd0 = 56'hF0CCAAF556678F;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int Pc2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
    29, 32
  };
  localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [55:0] cd_in = '0;
  logic        abort = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  key_schedule_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .cd_in        (cd_in),
    .abort        (abort),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] h, input int n);
    logic [55:0] t;
    t = {h, h} << n;
    return t[55:28];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-Pc2[i]];
    return k;
  endfunction

  // Standard DES schedule: K_r = PC2(C0 <<< cum_r || D0 <<< cum_r); decrypt emits it reversed.
  logic [47:0] m_keys [16];
  logic [55:0] m_cd;
  bit          m_active = 0;
  bit          m_done = 0;
  int          m_n = 0;

  task automatic build_keys(input logic dec, input logic [55:0] cd);
    logic [47:0] k [16];
    int cum;
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += Shifts[r];
      k[r] = pc2({rotl(cd[55:28], cum % 28), rotl(cd[27:0], cum % 28)});
    end
    for (int i = 0; i < 16; i++) m_keys[i] = dec ? k[15-i] : k[i];
    m_cd = cd;
  endtask

  logic [47:0] log_q [$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(subkey_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_idx", 64'(round_idx), 64'd0);
      m_active = 0;
      m_done   = 0;
      m_n      = 0;
    end else begin
      chk("valid", 64'(subkey_valid), 64'(m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      if (done) done_cnt++;
      if (m_active) begin
        chk("subkey", 64'(subkey), 64'(m_keys[m_n]));
        chk("round_idx", 64'(round_idx), 64'(m_n));
      end
      if (m_done) chk("cd_at_done", 64'(dut.cd_q), 64'(m_cd));
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          build_keys(decrypt, cd_in);
          m_active = 1;
          m_n      = 0;
        end
      end else if (abort) begin
        m_active = 0;
        m_n      = 0;
      end else if (subkey_ready) begin
        log_q.push_back(subkey);
        if (m_n == 15) begin
          m_active = 0;
          m_done   = 1;
          m_n      = 0;
        end else begin
          m_n++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic dec);
    start   = 1'b1;
    decrypt = dec;
    cd_in   = Cd0;
    cyc(1);
    start   = 1'b0;
    cd_in   = ~Cd0;
    decrypt = ~dec;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done) break;
      cyc(1);
    end
    if (i == budget) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic reset_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  logic [47:0] enc_ref [$];

  initial begin
    build_keys(1'b0, Cd0);
    chk("model_k1", 64'(m_keys[0]), 64'(K1));
    chk("model_k16", 64'(m_keys[15]), 64'(K16));
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Encrypt, full throughput
    reset_log();
    subkey_ready = 1'b1;
    do_start(1'b0);
    chk("s1_first", 64'(subkey), 64'(K1));
    wait_done(40);
    cyc(2);
    chk("s1_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      chk("s1_k1", 64'(log_q[0]), 64'(K1));
      chk("s1_k16", 64'(log_q[15]), 64'(K16));
    end
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    enc_ref = log_q;

    // Decrypt
    reset_log();
    do_start(1'b1);
    chk("s2_first", 64'(subkey), 64'(K16));
    wait_done(40);
    chk("s2_cd_restored", 64'(dut.cd_q), 64'(Cd0));
    cyc(2);
    chk("s2_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) chk("s2_last", 64'(log_q[15]), 64'(K1));

    // Encrypt with 3-cycle stall at round 4
    reset_log();
    do_start(1'b0);
    cyc(4);
    subkey_ready = 1'b0;
    chk("s3_idx_at_stall", 64'(round_idx), 64'd4);
    cyc(3);
    chk("s3_idx_held", 64'(round_idx), 64'd4);
    subkey_ready = 1'b1;
    wait_done(40);
    cyc(2);
    chk("s3_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16 && enc_ref.size() == 16)
      for (int i = 0; i < 16; i++) chk("s3_seq", 64'(log_q[i]), 64'(enc_ref[i]));

    // Abort at round 7, then restart
    reset_log();
    do_start(1'b0);
    cyc(7);
    chk("s4_idx", 64'(round_idx), 64'd7);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("s4_valid", 64'(subkey_valid), 64'd0);
    chk("s4_idx_clr", 64'(round_idx), 64'd0);
    cyc(2);
    chk("s4_no_done", 64'(done_cnt), 64'd0);
    do_start(1'b0);
    chk("s4_restart_k1", 64'(subkey), 64'(K1));
    wait_done(40);
    cyc(2);

    // start pulses while busy and in DONE are ignored
    reset_log();
    do_start(1'b0);
    cyc(3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(40);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("s5_count", 64'(log_q.size()), 64'd16);
    chk("s5_done_cnt", 64'(done_cnt), 64'd1);
    chk("s5_idle", 64'(subkey_valid), 64'd0);

    // Asynchronous reset mid-schedule
    do_start(1'b0);
    cyc(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_valid", 64'(subkey_valid), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_idx", 64'(round_idx), 64'd0);
    chk("s6_subkey", 64'(subkey), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("s6_post_valid", 64'(subkey_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
